comp_operand_capture: RTL and testbench

COMP_OPERAND_CAPTURE -- requirements
Module: comp_operand_capture

---
 rtl/comp_operand_capture_pkg.sv | 6 +
 rtl/debounce_bus.sv | 49 ++++
 rtl/comp_operand_capture.sv | 31 +++
 tb/tb_comp_operand_capture.sv | 100 ++++++++++
 4 files changed

// File: rtl/comp_operand_capture_pkg.sv
// comp_operand_capture_pkg: shared defaults and debounce FSM encoding
package comp_operand_capture_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int CNT_MAX_DEF = 240000;
  typedef enum logic {STABLE = 1'b0, BOUNCE = 1'b1} db_state_e;
endpackage

// File: rtl/debounce_bus.sv
// debounce_bus: 2-flop synchronizer plus stability-window debouncer for one bus
module debounce_bus
  import comp_operand_capture_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_MAX = CNT_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] val_o,
  output logic             chg_o
);
  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] LAST = CW'(CNT_MAX - 1);
  db_state_e state_q;
  logic [WIDTH-1:0] s1_q, s2_q, p_q, val_q;
  logic [CW-1:0] cnt_q;
  logic same, home;
  assign same = s2_q == p_q;
  assign home = s2_q == val_q;
  assign chg_o = state_q == BOUNCE && !home && same && cnt_q == LAST;
  assign val_o = val_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      p_q <= '0;
      val_q <= '0;
      cnt_q <= '0;
      state_q <= STABLE;
    end else begin
      s1_q <= in_i;
      s2_q <= s1_q;
      p_q <= s2_q;
      if (state_q == STABLE) begin
        cnt_q <= '0;
        if (!home) state_q <= BOUNCE;
      end else if (home) begin
        cnt_q <= '0;
        state_q <= STABLE;
      end else if (!same) cnt_q <= '0;
      else if (cnt_q == LAST) begin
        val_q <= s2_q;
        cnt_q <= '0;
        state_q <= STABLE;
      end else cnt_q <= cnt_q + CW'(1);
    end
endmodule

// File: rtl/comp_operand_capture.sv
// comp_operand_capture: debounced switch/key operands for the comparator, with update strobe
module comp_operand_capture
  import comp_operand_capture_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_MAX = CNT_MAX_DEF,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             upd
);
  localparam logic [WIDTH-1:0] KMASK = KEY_ACTIVE_LOW != 0 ? '1 : '0;
  logic [WIDTH-1:0] key_c;
  logic cx, cy, upd_q;
  assign key_c = key ^ KMASK;
  debounce_bus #(.WIDTH(WIDTH), .CNT_MAX(CNT_MAX)) u_x (
    .clk(clk), .rst_n(rst_n), .in_i(sw), .val_o(x), .chg_o(cx)
  );
  debounce_bus #(.WIDTH(WIDTH), .CNT_MAX(CNT_MAX)) u_y (
    .clk(clk), .rst_n(rst_n), .in_i(key_c), .val_o(y), .chg_o(cy)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) upd_q <= 1'b0;
    else upd_q <= cx | cy;
  assign upd = upd_q;
endmodule

// File: tb/tb_comp_operand_capture.sv
// tb_comp_operand_capture: directed checks of debounce latency, glitch rejection, reset and upd
module tb_comp_operand_capture;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] sw = 4'h0, key = 4'hF, x, y;
  logic upd;
  int checks = 0, errors = 0, updcnt = 0, u;
  comp_operand_capture #(.WIDTH(4), .CNT_MAX(4), .KEY_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .key(key), .x(x), .y(y), .upd(upd)
  );
  always #5 clk = ~clk;
  always @(posedge clk) #2 if (upd === 1'b1) updcnt++;
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick(3);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_upd", 32'(upd), 0);
    rst_n = 1'b1;
    tick(20);
    chk("idle_x", 32'(x), 0);
    chk("idle_y", 32'(y), 0);
    chk("idle_updcnt", 32'(updcnt), 0);
    u = updcnt;
    sw = 4'b0100;
    tick(6);
    chk("sw_step_early", 32'(x), 0);
    tick(1);
    chk("sw_step_x", 32'(x), 32'h4);
    chk("sw_step_upd", 32'(upd), 1);
    tick(1);
    chk("sw_step_upd_off", 32'(upd), 0);
    chk("sw_step_pulses", 32'(updcnt - u), 1);
    u = updcnt;
    for (int i = 0; i < 4; i++) begin
      key = i[0] ? 4'b1111 : 4'b1101;
      tick(2);
      chk("key_toggle_y", 32'(y), 0);
    end
    key = 4'b1101;
    tick(6);
    chk("key_hold_early", 32'(y), 0);
    chk("key_toggle_pulses", 32'(updcnt - u), 0);
    tick(1);
    chk("key_hold_y", 32'(y), 32'h2);
    chk("key_hold_upd", 32'(upd), 1);
    tick(1);
    chk("key_hold_pulses", 32'(updcnt - u), 1);
    u = updcnt;
    sw = 4'b1001;
    key = 4'b0110;
    tick(6);
    chk("both_early_x", 32'(x), 32'h4);
    chk("both_early_y", 32'(y), 32'h2);
    tick(1);
    chk("both_x", 32'(x), 32'h9);
    chk("both_y", 32'(y), 32'h9);
    chk("both_upd", 32'(upd), 1);
    tick(1);
    chk("both_upd_off", 32'(upd), 0);
    chk("both_pulses", 32'(updcnt - u), 1);
    sw = 4'h0;
    key = 4'hF;
    tick(10);
    chk("clear_x", 32'(x), 0);
    chk("clear_y", 32'(y), 0);
    u = updcnt;
    sw = 4'b1000;
    tick(3);
    sw = 4'h0;
    tick(12);
    chk("glitch_x", 32'(x), 0);
    chk("glitch_pulses", 32'(updcnt - u), 0);
    sw = 4'b0010;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("midrst_x", 32'(x), 0);
    chk("midrst_upd", 32'(upd), 0);
    tick(1);
    rst_n = 1'b1;
    u = updcnt;
    tick(6);
    chk("postrst_early", 32'(x), 0);
    chk("postrst_early_pulses", 32'(updcnt - u), 0);
    tick(1);
    chk("postrst_x", 32'(x), 32'h2);
    chk("postrst_upd", 32'(upd), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
